// File: rtl/regfile_alu_pipe_if.sv
// Operation/result bundle between the instruction driver and regfile_alu_pipe.
// master: instruction driver; slave: the datapath.
interface regfile_alu_pipe_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = 5
);
  logic             in_valid;
  logic [AW-1:0]    addr_a;
  logic [AW-1:0]    addr_b;
  logic [AW-1:0]    addr_d;
  logic [WIDTH-1:0] data_in;
  logic             asel;
  logic             bsel;
  logic [2:0]       opsel;
  logic             wen;
  logic             oen;
  logic             out_valid;
  logic [WIDTH-1:0] data_out;
  logic             over;

  modport master (
    output in_valid, addr_a, addr_b, addr_d, data_in, asel, bsel, opsel, wen, oen,
    input  out_valid, data_out, over
  );

  modport slave (
    input  in_valid, addr_a, addr_b, addr_d, data_in, asel, bsel, opsel, wen, oen,
    output out_valid, data_out, over
  );
endinterface

// File: rtl/regfile_alu_pipe.sv
// Two-stage register-file/ALU pipeline: S1 captures operands, S2 executes and writes back.
// A result bypass from S2 to the S1 operand muxes lets dependent operations issue every cycle.
// Optional feature: define REGFILE_ALU_SATURATE_EN to clamp overflowing ADD/SUB results.
module regfile_alu_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREG  = 32,
  parameter int unsigned AW    = $clog2(NREG)
) (
  input logic                clk,
  input logic                rst,
  regfile_alu_pipe_if.slave  bus_io
);

  localparam logic [2:0] OpAdd   = 3'b000;
  localparam logic [2:0] OpSub   = 3'b001;
  localparam logic [2:0] OpAnd   = 3'b010;
  localparam logic [2:0] OpOr    = 3'b011;
  localparam logic [2:0] OpXor   = 3'b100;
  localparam logic [2:0] OpPassA = 3'b101;
  localparam logic [2:0] OpSlt   = 3'b110;
  localparam logic [2:0] OpPassB = 3'b111;

  logic [WIDTH-1:0] rf_q [NREG];

  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;
  logic [2:0]       s1_op_q;
  logic [AW-1:0]    s1_addr_d_q;
  logic             s1_wen_q;
  logic             s1_oen_q;

  logic             out_valid_q;
  logic [WIDTH-1:0] data_out_q;
  logic             over_q;

  logic [WIDTH-1:0] op_a_d;
  logic [WIDTH-1:0] op_b_d;
  logic             byp_a;
  logic             byp_b;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             ovf_add;
  logic             ovf_sub;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;

  // ALU on the S1 registers; alu_res is also the write-back and bypass value.
  always_comb begin
    sum     = s1_a_q + s1_b_q;
    diff    = s1_a_q - s1_b_q;
    ovf_add = (s1_a_q[WIDTH-1] == s1_b_q[WIDTH-1]) && (sum[WIDTH-1] != s1_a_q[WIDTH-1]);
    ovf_sub = (s1_a_q[WIDTH-1] != s1_b_q[WIDTH-1]) && (diff[WIDTH-1] != s1_a_q[WIDTH-1]);
    alu_res = '0;
    alu_ovf = 1'b0;
    unique case (s1_op_q)
      OpAdd: begin
        alu_res = sum;
        alu_ovf = ovf_add;
      end
      OpSub: begin
        alu_res = diff;
        alu_ovf = ovf_sub;
      end
      OpAnd:   alu_res = s1_a_q & s1_b_q;
      OpOr:    alu_res = s1_a_q | s1_b_q;
      OpXor:   alu_res = s1_a_q ^ s1_b_q;
      OpPassA: alu_res = s1_a_q;
      OpSlt:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(s1_a_q) < $signed(s1_b_q))};
      OpPassB: alu_res = s1_b_q;
      default: alu_res = '0;
    endcase
`ifdef REGFILE_ALU_SATURATE_EN
    // Overflow direction follows the sign of A for both ADD and SUB.
    if (alu_ovf) begin
      alu_res = s1_a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  // Operand select with bypass of the in-flight result over the stale rf entry.
  always_comb begin
    byp_a  = s1_valid_q && s1_wen_q && (s1_addr_d_q == bus_io.addr_a);
    byp_b  = s1_valid_q && s1_wen_q && (s1_addr_d_q == bus_io.addr_b);
    op_a_d = bus_io.data_in;
    op_b_d = bus_io.data_in;
    if (bus_io.asel) begin
      op_a_d = byp_a ? alu_res : rf_q[bus_io.addr_a];
    end
    if (bus_io.bsel) begin
      op_b_d = byp_b ? alu_res : rf_q[bus_io.addr_b];
    end
  end

  // S1: capture operands and control when an operation is presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_op_q     <= '0;
      s1_addr_d_q <= '0;
      s1_wen_q    <= 1'b0;
      s1_oen_q    <= 1'b0;
    end else begin
      s1_valid_q <= bus_io.in_valid;
      if (bus_io.in_valid) begin
        s1_a_q      <= op_a_d;
        s1_b_q      <= op_b_d;
        s1_op_q     <= bus_io.opsel;
        s1_addr_d_q <= bus_io.addr_d;
        s1_wen_q    <= bus_io.wen;
        s1_oen_q    <= bus_io.oen;
      end
    end
  end

  // S2: register the result; data_out/over hold across bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
      over_q      <= 1'b0;
    end else begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        data_out_q <= s1_oen_q ? alu_res : '0;
        over_q     <= s1_oen_q & alu_ovf;
      end
    end
  end

  // Register file write-back; reset wins, discarding an in-flight write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) begin
        rf_q[i] <= '0;
      end
    end else if (s1_valid_q && s1_wen_q) begin
      rf_q[s1_addr_d_q] <= alu_res;
    end
  end

  assign bus_io.out_valid = out_valid_q;
  assign bus_io.data_out  = data_out_q;
  assign bus_io.over      = over_q;

endmodule

// File: doc/regfile_alu_pipe.md
Name: regfile_alu_pipe

Overview:
- Parametrised successor of the single-cycle register-file/ALU datapath.
- Contains an NREG x WIDTH register file, two read ports, one write-back port, and an 8-op ALU.
- Two-stage pipeline (operand capture, execute/write-back) with a valid handshake and a result bypass, so dependent back-to-back operations issue every cycle.
- Sits between the instruction driver and the output bus; `over` reports signed overflow.

Parameters:
- WIDTH, 32, datapath and register width in bits (>=8).
- NREG, 32, number of registers (power of two, >=2).
- AW, $clog2(NREG), register address width (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operation present this cycle.
- addr_a  input  AW  read address, operand A.
- addr_b  input  AW  read address, operand B.
- addr_d  input  AW  write-back destination.
- data_in  input  WIDTH  immediate / store data.
- asel  input  1  1 = A from rf[addr_a]; 0 = A from data_in.
- bsel  input  1  1 = B from rf[addr_b]; 0 = B from data_in.
- opsel  input  3  ALU operation.
- wen  input  1  write result to rf[addr_d].
- oen  input  1  drive result onto data_out.
- out_valid  output  1  result valid.
- data_out  output  WIDTH  result (0 when oen was low).
- over  output  1  signed overflow of the result.

Behaviour:
- Design has one clock; reset is synchronous and active-high. Ports are named clk and rst.
- Reset, when rst is sampled high:
  - All rf entries go to 0.
  - S1 valid goes to 0.
  - out_valid, data_out and over go to 0.
  - rst overrides in_valid in the same cycle. An operation in flight is discarded, with no write-back.
- Stage S1: at edge E0 with in_valid=1, the block captures:
  - operand A and operand B;
  - opsel, addr_d, wen and oen.
- Stage S2: the ALU operates combinationally on the S1 registers. At edge E1 the block:
  - registers data_out and over;
  - sets out_valid=1;
  - writes rf[addr_d] when S1 valid and wen are both high.
- Latency: inputs at edge E0 produce out_valid at E1. That is a 2-edge latency, with throughput of 1 per cycle.
- out_valid follows S1 valid exactly. When there is no valid operation, data_out and over hold their previous value and out_valid=0.
- Bypass: if S1 is valid, S1 wen=1 and S1 addr_d equals addr_a (or addr_b) of the new operation with asel (or bsel) set, that operand takes the ALU result, not the stale rf value.
- An operation two or more cycles later reads the rf directly.
- No register is hardwired to zero.
- opsel encoding:
  - 000 ADD
  - 001 SUB (A-B)
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 PASSA
  - 110 SLT (signed A<B gives 1, else 0)
  - 111 PASSB
- Arithmetic is two's complement modulo 2^WIDTH.
- over is set on signed overflow for ADD/SUB: operands of the same sign (ADD), or of differing sign (SUB), give a result whose sign differs from A. over=0 for all other ops.
- oen=0: data_out is forced to 0 and over to 0. Write-back still occurs. out_valid is unaffected.
- Write-back occurs regardless of over.
- Writing the register being read in the same cycle is handled by the bypass.

Optional Feature:
- Macro: REGFILE_ALU_SATURATE_EN.
- Defined:
  - ADD/SUB results that overflow clamp to the most positive (2^(WIDTH-1)-1) or most negative (-2^(WIDTH-1)) value.
  - The clamped value is both output and written back; over is still asserted.
- Undefined: results wrap, as in the base behaviour.

Test Plan:
- Store and read:
  - PASSB with bsel=0 and wen, storing -17 (32'hFFFF_FFEF) to r0, 17 to r1, 34 to r2 and 68 to r22.
  - Then PASSA with asel=1 on r2 -> data_out=34, out_valid one edge after capture.
- Dependent ADD/SUB, issued consecutively with the bypass exercised:
  - ADD r0,r1->r1 gives 0.
  - ADD r1,r2->r1 gives 34.
  - SUB r0,r22->r22 gives 32'hFFFF_FFAB.
  - Read back r1=34 and r22=32'hFFFF_FFAB; over=0 throughout.
- Overflow: ADD 32'h7FFF_FFFF + 1:
  - without the macro -> data_out=32'h8000_0000, over=1;
  - with REGFILE_ALU_SATURATE_EN -> 32'h7FFF_FFFF, over=1.
  - SUB 32'h8000_0000 - 1 with the macro -> 32'h8000_0000, over=1.
- oen low: ADD r1,r2 with oen=0 and wen=1 -> data_out=0, over=0, out_valid=1. A later read of addr_d returns the sum.
- Reset mid-operation: assert rst in the cycle after in_valid of a wen write to r5=99 -> out_valid=0, data_out=0, and r5 reads 0 after reset.
- Bubble: in_valid low for 3 cycles -> out_valid low, and data_out holds the last value.
